// File: rtl/motor_speed_ctrl_pkg.sv
// Shared definitions for the scan-motor speed regulator: one-hot FSM encodings and default limits.
// Optional index glitch filter is enabled by defining MOTOR_SPEED_CTRL_DEBOUNCE_EN.
package motor_speed_ctrl_pkg;

   typedef logic [3:0] state_t;

   localparam state_t ST_IDLE  = 4'b0001;
   localparam state_t ST_SPIN  = 4'b0010;
   localparam state_t ST_TRACK = 4'b0100;
   localparam state_t ST_FAULT = 4'b1000;

   localparam int unsigned PWM_PERIOD_DEF = 32'd1000;
   localparam int unsigned START_HIGH_DEF = 32'd400;
   localparam int unsigned MIN_HIGH_DEF   = 32'd50;
   localparam int unsigned MAX_HIGH_DEF   = 32'd950;

   function automatic logic [15:0] pwm_low(input logic [15:0] period, input logic [15:0] high);
      return period - high;
   endfunction

endpackage

// File: rtl/index_period_meas.sv
// Index sensor front end: synchronizer, optional glitch filter (MOTOR_SPEED_CTRL_DEBOUNCE_EN),
// rising-edge strobe and a saturating revolution-period counter with stall compare.
module index_period_meas
   import motor_speed_ctrl_pkg::*;
#(
   parameter int unsigned       MEAS_W    = 32'd24,
   parameter logic [MEAS_W-1:0] STALL_CYC = {MEAS_W{1'b1}}
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              restart,
   input  logic              index_in,
   output logic              idx_edge,
   output logic [MEAS_W-1:0] period,
   output logic              stall_evt
);

   logic              idx_meta_r;
   logic              idx_sync_r;
   logic              idx_prev_r;
   logic              idx_edge_r;
   logic              idx_lvl_s;
   logic [MEAS_W-1:0] count_r;
   logic [MEAS_W-1:0] count_inc_s;

   // two-flop synchronizer for the asynchronous sensor
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_meta_r <= 1'b0;
         idx_sync_r <= 1'b0;
      end else begin
         idx_meta_r <= index_in;
         idx_sync_r <= idx_meta_r;
      end
   end

`ifdef MOTOR_SPEED_CTRL_DEBOUNCE_EN
   logic       idx_filt_r;
   logic [3:0] stable_r;

   // level follows the synced input only after 16 consecutive differing cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_filt_r <= 1'b0;
         stable_r   <= 4'd0;
      end else if (idx_sync_r != idx_filt_r) begin
         if (stable_r == 4'd15) begin
            idx_filt_r <= idx_sync_r;
            stable_r   <= 4'd0;
         end else begin
            stable_r <= stable_r + 4'd1;
         end
      end else begin
         stable_r <= 4'd0;
      end
   end

   assign idx_lvl_s = idx_filt_r;
`else
   assign idx_lvl_s = idx_sync_r;
`endif

   // registered rising-edge strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_prev_r <= 1'b0;
         idx_edge_r <= 1'b0;
      end else begin
         idx_prev_r <= idx_lvl_s;
         idx_edge_r <= idx_lvl_s & ~idx_prev_r;
      end
   end

   // saturating increment; also the period reported on an edge
   always_comb begin
      if (count_r == {MEAS_W{1'b1}}) begin
         count_inc_s = count_r;
      end else begin
         count_inc_s = count_r + {{(MEAS_W-1){1'b0}}, 1'b1};
      end
   end

   // period counter, cleared on every edge and on spin-up entry
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= {MEAS_W{1'b0}};
      end else if (restart || idx_edge_r) begin
         count_r <= {MEAS_W{1'b0}};
      end else begin
         count_r <= count_inc_s;
      end
   end

   assign idx_edge  = idx_edge_r;
   assign period    = count_inc_s;
   assign stall_evt = (count_r >= STALL_CYC);

endmodule

// File: rtl/motor_speed_ctrl.sv
// Closed-loop scan-motor speed regulator driving the PWM stage (enable, high_cnt, low_cnt).
// Build option MOTOR_SPEED_CTRL_DEBOUNCE_EN adds a glitch filter on the index path.
module motor_speed_ctrl
   import motor_speed_ctrl_pkg::*;
#(
   parameter int unsigned       PWM_PERIOD = PWM_PERIOD_DEF,
   parameter int unsigned       MEAS_W     = 32'd24,
   parameter int unsigned       START_HIGH = START_HIGH_DEF,
   parameter int unsigned       MIN_HIGH   = MIN_HIGH_DEF,
   parameter int unsigned       MAX_HIGH   = MAX_HIGH_DEF,
   parameter int unsigned       GAIN_SHIFT = 32'd6,
   parameter int unsigned       LOCK_TOL   = 32'd64,
   parameter int unsigned       LOCK_REVS  = 32'd4,
   parameter logic [MEAS_W-1:0] STALL_CYC  = {MEAS_W{1'b1}}
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [MEAS_W-1:0] target_period,
   input  logic              index_in,
   output logic              pwm_en,
   output logic [15:0]       high_cnt,
   output logic [15:0]       low_cnt,
   output logic [MEAS_W-1:0] meas_period,
   output logic              meas_valid,
   output logic              locked,
   output logic              stall
);

   localparam int unsigned ERR_W = MEAS_W + 32'd1;
   localparam int unsigned SUM_W = MEAS_W + 32'd2;
   localparam int unsigned LCW   = $clog2(LOCK_REVS + 32'd1);

   localparam logic [15:0]             PERIOD_C     = 16'(PWM_PERIOD);
   localparam logic [15:0]             START_HIGH_C = 16'(START_HIGH);
   localparam logic signed [SUM_W-1:0] MIN_C        = $signed(SUM_W'(MIN_HIGH));
   localparam logic signed [SUM_W-1:0] MAX_C        = $signed(SUM_W'(MAX_HIGH));
   localparam logic [ERR_W-1:0]        LOCK_TOL_C   = ERR_W'(LOCK_TOL);
   localparam logic [LCW-1:0]          LOCK_REVS_C  = LCW'(LOCK_REVS);

   state_t              state_r;
   logic                spin_seen_r;
   logic                pwm_en_r;
   logic [15:0]         high_cnt_r;
   logic [15:0]         low_cnt_r;
   logic [MEAS_W-1:0]   meas_period_r;
   logic                meas_valid_r;
   logic [MEAS_W-1:0]   target_r;
   logic                locked_r;
   logic                stall_r;
   logic [LCW-1:0]      lock_cnt_r;

   logic                idx_edge_s;
   logic [MEAS_W-1:0]   period_s;
   logic                stall_evt_s;
   logic                restart_s;
   logic signed [ERR_W-1:0] err_s;
   logic signed [ERR_W-1:0] step_s;
   logic signed [SUM_W-1:0] sum_s;
   logic [ERR_W-1:0]    abs_err_s;
   logic [15:0]         high_next_s;
   logic [LCW-1:0]      lock_cnt_next_s;

   index_period_meas #(
      .MEAS_W    (MEAS_W),
      .STALL_CYC (STALL_CYC)
   ) u_meas (
      .clk       (clk),
      .rst       (rst),
      .restart   (restart_s),
      .index_in  (index_in),
      .idx_edge  (idx_edge_s),
      .period    (period_s),
      .stall_evt (stall_evt_s)
   );

   // the period counter and stall timer restart on the IDLE -> SPIN transition
   always_comb begin
      if ((state_r == ST_IDLE) && enable) begin
         restart_s = 1'b1;
      end else begin
         restart_s = 1'b0;
      end
   end

   // integrating duty step and lock bookkeeping for the registered measurement
   always_comb begin
      err_s  = $signed({1'b0, meas_period_r} - {1'b0, target_r});
      step_s = err_s >>> GAIN_SHIFT;
      sum_s  = $signed({{(SUM_W-16){1'b0}}, high_cnt_r} + {step_s[ERR_W-1], step_s});
      if (sum_s < MIN_C) begin
         high_next_s = 16'(MIN_HIGH);
      end else if (sum_s > MAX_C) begin
         high_next_s = 16'(MAX_HIGH);
      end else begin
         high_next_s = sum_s[15:0];
      end
      if (err_s[ERR_W-1]) begin
         abs_err_s = $unsigned(-err_s);
      end else begin
         abs_err_s = $unsigned(err_s);
      end
      if (abs_err_s > LOCK_TOL_C) begin
         lock_cnt_next_s = {LCW{1'b0}};
      end else if (lock_cnt_r >= LOCK_REVS_C) begin
         lock_cnt_next_s = LOCK_REVS_C;
      end else begin
         lock_cnt_next_s = lock_cnt_r + LCW'(32'd1);
      end
   end

   // regulator FSM with all outputs registered
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= ST_IDLE;
         spin_seen_r   <= 1'b0;
         pwm_en_r      <= 1'b0;
         high_cnt_r    <= START_HIGH_C;
         low_cnt_r     <= pwm_low(PERIOD_C, START_HIGH_C);
         meas_period_r <= {MEAS_W{1'b0}};
         meas_valid_r  <= 1'b0;
         target_r      <= {MEAS_W{1'b0}};
         locked_r      <= 1'b0;
         stall_r       <= 1'b0;
         lock_cnt_r    <= {LCW{1'b0}};
      end else begin
         meas_valid_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               pwm_en_r <= 1'b0;
               if (enable) begin
                  state_r     <= ST_SPIN;
                  pwm_en_r    <= 1'b1;
                  spin_seen_r <= 1'b0;
                  lock_cnt_r  <= {LCW{1'b0}};
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_SPIN, ST_TRACK: begin
               if (!enable) begin
                  state_r    <= ST_IDLE;
                  pwm_en_r   <= 1'b0;
                  locked_r   <= 1'b0;
                  lock_cnt_r <= {LCW{1'b0}};
                  high_cnt_r <= START_HIGH_C;
                  low_cnt_r  <= pwm_low(PERIOD_C, START_HIGH_C);
               end else if (stall_evt_s) begin
                  state_r    <= ST_FAULT;
                  pwm_en_r   <= 1'b0;
                  stall_r    <= 1'b1;
                  locked_r   <= 1'b0;
                  lock_cnt_r <= {LCW{1'b0}};
                  high_cnt_r <= START_HIGH_C;
                  low_cnt_r  <= pwm_low(PERIOD_C, START_HIGH_C);
               end else begin
                  // the first edge after spin-up closes a partial revolution
                  if (idx_edge_s) begin
                     if ((state_r == ST_SPIN) && !spin_seen_r) begin
                        spin_seen_r <= 1'b1;
                     end else begin
                        state_r       <= ST_TRACK;
                        meas_period_r <= period_s;
                        meas_valid_r  <= 1'b1;
                        target_r      <= target_period;
                     end
                  end
                  if (meas_valid_r) begin
                     high_cnt_r <= high_next_s;
                     low_cnt_r  <= pwm_low(PERIOD_C, high_next_s);
                     lock_cnt_r <= lock_cnt_next_s;
                     locked_r   <= (lock_cnt_next_s >= LOCK_REVS_C);
                  end
               end
            end
            ST_FAULT: begin
               pwm_en_r <= 1'b0;
               if (!enable) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_FAULT;
               end
            end
            default: begin
               state_r  <= ST_IDLE;
               pwm_en_r <= 1'b0;
            end
         endcase
      end
   end

   assign pwm_en      = pwm_en_r;
   assign high_cnt    = high_cnt_r;
   assign low_cnt     = low_cnt_r;
   assign meas_period = meas_period_r;
   assign meas_valid  = meas_valid_r;
   assign locked      = locked_r;
   assign stall       = stall_r;

endmodule
